key_stream_matcher: RTL and testbench

Streaming search stage fed by the key/enable control registers. It takes an Avalon-ST byte stream and forwards it unchanged through a one-cycle register slice. While it does so, it searches each packet for the 12-symbol key held in the control registers. On the end-of-packet beat it flags whether the key occurred in that packet, and it keeps a saturating count of matching packets.

---
 rtl/key_stream_matcher.sv | 165 ++++++++++++++++
 tb/tb_key_stream_matcher.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_stream_matcher.sv
// -----------------------------------------------------------------------------
// key_stream_matcher
//
// Passes an Avalon-ST symbol stream through a one-cycle register slice. While
// doing so it searches each packet for a KEY_LEN-symbol key taken from the key
// registers. On the end-of-packet output beat, key_found_o reports whether the
// key occurred anywhere in that packet. match_cnt_o is a saturating count of
// packets in which the key was found.
//
// Ports
//   clk_i, arst_n_i          clock, asynchronous active-low reset
//   pattern_i[REG_DEPTH]     key words; symbol 0 is the most significant byte
//                            of word 0 (bits 0:7 in ascending numbering)
//   wrken_i                  search enable, latched at sop
//   snk_*                    input stream (data/valid/sop/eop, ready out)
//   src_*                    output stream (data/valid/sop/eop, ready in)
//   key_found_o              meaningful only with src_valid_o & src_eop_o
//   match_cnt_o              saturating count of packets containing the key
// -----------------------------------------------------------------------------
module key_stream_matcher #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_DEPTH  = 3,
  parameter int SYMBOL_W   = 8,
  parameter int CNT_W      = 16
) (
  input  logic                  clk_i,
  input  logic                  arst_n_i,
  input  logic [DATA_WIDTH-1:0] pattern_i [REG_DEPTH],
  input  logic                  wrken_i,
  input  logic [SYMBOL_W-1:0]   snk_data_i,
  input  logic                  snk_valid_i,
  input  logic                  snk_sop_i,
  input  logic                  snk_eop_i,
  output logic                  snk_ready_o,
  output logic [SYMBOL_W-1:0]   src_data_o,
  output logic                  src_valid_o,
  output logic                  src_sop_o,
  output logic                  src_eop_o,
  input  logic                  src_ready_i,
  output logic                  key_found_o,
  output logic [CNT_W-1:0]      match_cnt_o
);

  localparam int KEY_LEN       = REG_DEPTH * DATA_WIDTH / SYMBOL_W;
  localparam int SYMS_PER_WORD = DATA_WIDTH / SYMBOL_W;
  localparam int FILL_W        = $clog2(KEY_LEN);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(KEY_LEN - 1);

  typedef enum logic {IDLE, IN_PKT} state_e;

  state_e              state_q, state_d;
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic                found_q, found_d;
  logic                en_q, en_d;
  logic [SYMBOL_W-1:0] key_q [KEY_LEN];
  logic [SYMBOL_W-1:0] key_d [KEY_LEN];
  logic [SYMBOL_W-1:0] win_q [KEY_LEN-1];   // win_q[0] is the oldest symbol

  logic accept;
  logic searched_beat;
  logic window_match;
  logic hit;
  logic beat_found;

  // Ready depends only on slice state and downstream ready, never on valid.
  assign snk_ready_o   = ~src_valid_o | src_ready_i;
  assign accept        = snk_valid_i & snk_ready_o;
  assign searched_beat = accept & (snk_sop_i | (state_q == IN_PKT));

  // Unpack the key words: symbol 0 sits in the most significant byte.
  always_comb begin
    for (int k = 0; k < KEY_LEN; k++) begin
      key_d[k] = pattern_i[k / SYMS_PER_WORD][DATA_WIDTH-1-SYMBOL_W*(k % SYMS_PER_WORD) -: SYMBOL_W];
    end
  end

  // Window plus current symbol against the latched key, oldest to symbol 0.
  always_comb begin
    window_match = (snk_data_i == key_q[KEY_LEN-1]);
    for (int i = 0; i < KEY_LEN - 1; i++) begin
      if (win_q[i] != key_q[i]) window_match = 1'b0;
    end
  end

  // A sop beat starts a fresh window (fill becomes 1), so it can never hit.
  assign hit = accept & ~snk_sop_i & (state_q == IN_PKT) & en_q &
               (fill_q == FILL_FULL) & window_match;

  assign beat_found = snk_eop_i & ~snk_sop_i & (state_q == IN_PKT) & (found_q | hit);

  // NOTE: every variable driven here gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    found_d = found_q;
    en_d    = en_q;
    if (accept) begin
      if (snk_sop_i) begin
        // A sop restarts the search even if the previous packet lacked eop.
        state_d = snk_eop_i ? IDLE : IN_PKT;
        fill_d  = FILL_W'(1);
        found_d = 1'b0;
        en_d    = wrken_i;
      end else if (state_q == IN_PKT) begin
        state_d = snk_eop_i ? IDLE : IN_PKT;
        if (fill_q != FILL_FULL) fill_d = fill_q + FILL_W'(1);
        found_d = ~snk_eop_i & (found_q | hit);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together on the edge.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q <= IDLE;
      fill_q  <= '0;
      found_q <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      found_q <= found_d;
      en_q    <= en_d;
    end
  end

  // NOTE: key and window storage carry no reset; fill and state gate every use,
  // so their contents are don't-care until a sop has loaded them.
  // The window is shifted rather than cleared at sop; stale entries are never
  // compared because fill restarts at 1.
  always_ff @(posedge clk_i) begin
    if (searched_beat) begin
      for (int i = 0; i < KEY_LEN - 2; i++) win_q[i] <= win_q[i+1];
      win_q[KEY_LEN-2] <= snk_data_i;
    end
    if (accept & snk_sop_i) key_q <= key_d;
  end

  // Output register slice and matched-packet counter.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      src_valid_o <= 1'b0;
      src_data_o  <= '0;
      src_sop_o   <= 1'b0;
      src_eop_o   <= 1'b0;
      key_found_o <= 1'b0;
      match_cnt_o <= '0;
    end else begin
      if (accept) begin
        src_valid_o <= 1'b1;
        src_data_o  <= snk_data_i;
        src_sop_o   <= snk_sop_i;
        src_eop_o   <= snk_eop_i;
        key_found_o <= beat_found;
        if (beat_found && (match_cnt_o != {CNT_W{1'b1}})) begin
          match_cnt_o <= match_cnt_o + CNT_W'(1);
        end
      end else if (src_ready_i) begin
        src_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_key_stream_matcher.sv
// -----------------------------------------------------------------------------
// tb_key_stream_matcher
//
// Drives directed and randomized packets into key_stream_matcher and compares
// every output cycle against a packet-level reference model: each packet's
// symbols are collected in a queue and searched for the key as a plain
// substring match. A second instance with a 4-bit counter shares the stimulus
// so counter saturation is reached within a short run.
// -----------------------------------------------------------------------------
module tb_key_stream_matcher;

  localparam int DW = 32;
  localparam int RD = 3;
  localparam int SW = 8;
  localparam int CW = 16;
  localparam int KL = 12;

  logic          clk_i = 1'b0;
  logic          arst_n_i = 1'b1;
  logic [DW-1:0] pattern_i [RD];
  logic          wrken_i;
  logic [SW-1:0] snk_data_i;
  logic          snk_valid_i, snk_sop_i, snk_eop_i;
  logic          snk_ready_o;
  logic [SW-1:0] src_data_o;
  logic          src_valid_o, src_sop_o, src_eop_o;
  logic          src_ready_i;
  logic          key_found_o;
  logic [CW-1:0] match_cnt_o;

  logic          n_snk_ready;
  logic [SW-1:0] n_src_data;
  logic          n_src_valid, n_src_sop, n_src_eop, n_key_found;
  logic [3:0]    n_match_cnt;

  key_stream_matcher #(.DATA_WIDTH(DW), .REG_DEPTH(RD), .SYMBOL_W(SW), .CNT_W(CW)) dut (
    .clk_i(clk_i), .arst_n_i(arst_n_i), .pattern_i(pattern_i), .wrken_i(wrken_i),
    .snk_data_i(snk_data_i), .snk_valid_i(snk_valid_i), .snk_sop_i(snk_sop_i),
    .snk_eop_i(snk_eop_i), .snk_ready_o(snk_ready_o),
    .src_data_o(src_data_o), .src_valid_o(src_valid_o), .src_sop_o(src_sop_o),
    .src_eop_o(src_eop_o), .src_ready_i(src_ready_i),
    .key_found_o(key_found_o), .match_cnt_o(match_cnt_o)
  );

  key_stream_matcher #(.DATA_WIDTH(DW), .REG_DEPTH(RD), .SYMBOL_W(SW), .CNT_W(4)) dut_narrow (
    .clk_i(clk_i), .arst_n_i(arst_n_i), .pattern_i(pattern_i), .wrken_i(wrken_i),
    .snk_data_i(snk_data_i), .snk_valid_i(snk_valid_i), .snk_sop_i(snk_sop_i),
    .snk_eop_i(snk_eop_i), .snk_ready_o(n_snk_ready),
    .src_data_o(n_src_data), .src_valid_o(n_src_valid), .src_sop_o(n_src_sop),
    .src_eop_o(n_src_eop), .src_ready_i(src_ready_i),
    .key_found_o(n_key_found), .match_cnt_o(n_match_cnt)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [7:0]  d;
    logic        s;
    logic        e;
    logic        kf;
    int unsigned cnt;
    int          acc_cyc;
    bit          shown;
  } beat_t;

  beat_t       exp_q[$];
  string       key_str;
  byte         m_key [KL];
  byte         m_pkt[$];
  bit          m_in_pkt = 0;
  bit          m_en = 0;
  int unsigned m_cnt = 0;
  int unsigned shown_cnt = 0;
  logic        last_kf = 1'b0;
  int          cyc = 0;
  bit          chk_en = 0;
  bit          gaps = 0;
  bit          rnd_ready = 0;

  always @(posedge clk_i) cyc++;

  function automatic bit pkt_has_key();
    if (m_pkt.size() < KL) return 1'b0;
    for (int s = 0; s <= m_pkt.size() - KL; s++) begin
      bit ok = 1'b1;
      for (int j = 0; j < KL; j++) if (m_pkt[s+j] != m_key[j]) ok = 1'b0;
      if (ok) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_accept();
    beat_t b;
    b.d = snk_data_i; b.s = snk_sop_i; b.e = snk_eop_i; b.kf = 1'b0;
    if (snk_sop_i) begin
      m_in_pkt = 1'b1;
      m_pkt.delete();
      m_en = wrken_i;
      for (int j = 0; j < KL; j++) m_key[j] = key_str[j];
    end
    if (m_in_pkt) m_pkt.push_back(snk_data_i);
    if (snk_eop_i && m_in_pkt) begin
      b.kf = m_en && pkt_has_key();
      m_in_pkt = 1'b0;
      if (b.kf && m_cnt != 65535) m_cnt++;
    end
    b.cnt = m_cnt; b.acc_cyc = cyc; b.shown = 1'b0;
    exp_q.push_back(b);
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_pkt.delete();
    m_in_pkt = 1'b0;
    m_en = 1'b0;
    m_cnt = 0;
    shown_cnt = 0;
  endtask

  // ---------------- compare process (negedge, away from the active edge) ----
  always @(negedge clk_i) begin
    if (arst_n_i && chk_en) begin
      check("snk_ready", snk_ready_o, !src_valid_o || src_ready_i);
      check("narrow_ready", n_snk_ready, snk_ready_o);
      if (src_valid_o) begin
        if (exp_q.size() == 0) begin
          check("spurious_beat", 1, 0);
        end else begin
          if (!exp_q[0].shown) begin
            check("latency", cyc, exp_q[0].acc_cyc + 1);
            exp_q[0].shown = 1'b1;
            shown_cnt = exp_q[0].cnt;
            if (exp_q[0].e) last_kf = key_found_o;
          end
          check("src_data", src_data_o, exp_q[0].d);
          check("src_sop", src_sop_o, exp_q[0].s);
          check("src_eop", src_eop_o, exp_q[0].e);
          if (exp_q[0].e) check("key_found", key_found_o, exp_q[0].kf);
          if (src_ready_i) void'(exp_q.pop_front());
        end
      end else begin
        check("lost_beat", exp_q.size(), 0);
      end
      check("match_cnt", match_cnt_o, shown_cnt);
      check("narrow_cnt", n_match_cnt, (shown_cnt > 15) ? 15 : shown_cnt);
      if (snk_valid_i && snk_ready_o) model_accept();
    end
  end

  // Downstream ready: random when enabled, otherwise always ready.
  initial begin
    src_ready_i = 1'b1;
    forever begin
      @(posedge clk_i); #1;
      src_ready_i = rnd_ready ? 1'($urandom_range(1, 0)) : 1'b1;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_key(input string k);
    key_str = k;
    for (int w = 0; w < RD; w++) pattern_i[w] = {k[4*w], k[4*w+1], k[4*w+2], k[4*w+3]};
  endtask

  // Entered and left at posedge+1.
  task automatic send_beat(input logic [7:0] d, input logic s, input logic e);
    int budget;
    while (gaps && $urandom_range(3, 0) == 0) begin
      snk_valid_i = 1'b0;
      @(posedge clk_i); #1;
    end
    snk_valid_i = 1'b1; snk_data_i = d; snk_sop_i = s; snk_eop_i = e;
    budget = 0;
    @(negedge clk_i);
    while (!snk_ready_o && budget < 2000) begin
      budget++;
      @(negedge clk_i);
    end
    if (!snk_ready_o) check("accept_timeout", 0, 1);
    @(posedge clk_i); #1;
    snk_valid_i = 1'b0; snk_sop_i = 1'b0; snk_eop_i = 1'b0;
  endtask

  task automatic send_pkt(input string p, input bit with_sop = 1, input bit with_eop = 1,
                          input bit drop_en = 0);
    for (int i = 0; i < p.len(); i++) begin
      send_beat(p[i], with_sop && (i == 0), with_eop && (i == p.len() - 1));
      if (drop_en && i == 0) wrken_i = 1'b0;
    end
  endtask

  task automatic drain();
    int budget = 0;
    while (exp_q.size() != 0 && budget < 2000) begin
      @(posedge clk_i);
      budget++;
    end
    @(negedge clk_i); #1;
    check("drain_timeout", exp_q.size(), 0);
    @(posedge clk_i); #1;
  endtask

  function automatic string rand_str(input int len);
    string s = "";
    for (int i = 0; i < len; i++) s = {s, $sformatf("%c", 8'h41 + $urandom_range(11, 0))};
    return s;
  endfunction

  // Watchdog: the run must end on its own.
  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    string p;
    snk_valid_i = 1'b0; snk_sop_i = 1'b0; snk_eop_i = 1'b0; snk_data_i = '0;
    wrken_i = 1'b1;
    set_key("ABCDEFGHIJKL");

    // Asynchronous reset: outputs must clear with no clock edge.
    #1 arst_n_i = 1'b0;
    #1;
    check("rst_valid", src_valid_o, 0);
    check("rst_data", src_data_o, 0);
    check("rst_sop", src_sop_o, 0);
    check("rst_eop", src_eop_o, 0);
    check("rst_found", key_found_o, 0);
    check("rst_cnt", match_cnt_o, 0);
    check("rst_ready", snk_ready_o, 1);
    check("rst_narrow_cnt", n_match_cnt, 0);
    repeat (3) @(posedge clk_i);
    #1 arst_n_i = 1'b1;
    chk_en = 1'b1;

    // Key inside a longer packet.
    send_pkt("xxABCDEFGHIJKLyy"); drain();
    check("t1_found", last_kf, 1);
    check("t1_cnt", match_cnt_o, 1);

    // Key exactly fills the packet, then one symbol short.
    send_pkt("ABCDEFGHIJKL"); drain();
    check("t2_found", last_kf, 1);
    check("t2_cnt", match_cnt_o, 2);
    send_pkt("ABCDEFGHIJK"); drain();
    check("t2_short_found", last_kf, 0);
    check("t2_short_cnt", match_cnt_o, 2);

    // Key twice in one packet counts once.
    send_pkt("ABCDEFGHIJKLABCDEFGHIJKL"); drain();
    check("t3_found", last_kf, 1);
    check("t3_cnt", match_cnt_o, 3);

    // Key split across two packets.
    send_pkt("ABCDEF"); drain();
    check("t4_first_found", last_kf, 0);
    send_pkt("GHIJKL"); drain();
    check("t4_second_found", last_kf, 0);
    check("t4_cnt", match_cnt_o, 3);

    // Enable dropped after sop: still searched with the latched enable.
    send_pkt("zABCDEFGHIJKL", 1, 1, 1); drain();
    check("t5_found", last_kf, 1);
    check("t5_cnt", match_cnt_o, 4);
    // Enable low at sop: never found.
    wrken_i = 1'b0;
    send_pkt("ABCDEFGHIJKL"); drain();
    check("t6_found", last_kf, 0);
    check("t6_cnt", match_cnt_o, 4);
    wrken_i = 1'b1;

    // Asynchronous reset between edges in the middle of a packet.
    send_pkt("ABC", 1, 0);
    #2 arst_n_i = 1'b0;
    model_reset();
    #1;
    check("mid_rst_valid", src_valid_o, 0);
    check("mid_rst_data", src_data_o, 0);
    check("mid_rst_sop", src_sop_o, 0);
    check("mid_rst_cnt", match_cnt_o, 0);
    check("mid_rst_ready", snk_ready_o, 1);
    @(posedge clk_i); #1 arst_n_i = 1'b1;
    last_kf = 1'b1;
    send_pkt("DEFGHIJKL", 0, 1); drain();
    check("t7_found", last_kf, 0);
    check("t7_cnt", match_cnt_o, 0);

    // Randomized traffic with input gaps and downstream stalls.
    gaps = 1'b1;
    rnd_ready = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      int kind = $urandom_range(19, 0);
      if ($urandom_range(29, 0) == 0) set_key(($urandom_range(1, 0) != 0) ? "ABCDEFGHIJKL" : "LKJIHGFEDCBA");
      wrken_i = ($urandom_range(9, 0) != 0);
      if ($urandom_range(1, 0) != 0) p = {rand_str($urandom_range(6, 0)), key_str, rand_str($urandom_range(6, 0))};
      else p = rand_str($urandom_range(20, 1));
      if (kind == 0) send_pkt(p, 1, 0);       // missing eop
      else if (kind == 1) send_pkt(p, 0, 1);  // stray beats with no sop
      else send_pkt(p);
    end
    rnd_ready = 1'b0;
    gaps = 1'b0;
    @(posedge clk_i); #1;
    drain();
    check("final_cnt", match_cnt_o, m_cnt);
    check("narrow_saturated", n_match_cnt, 4'hF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
